// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and command layout for the ALU issuer.
package alu_pkg;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_MUL   = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_SHL_A = 3'd4;
    localparam logic [2:0] OP_SHR_A = 3'd5;
    localparam logic [2:0] OP_SHL_B = 3'd6;
    localparam logic [2:0] OP_SHR_B = 3'd7;

    localparam logic [7:0] DIV_ZERO_RESULT = 8'hFF;

    // Queue entry is {op, a, b}
    localparam int CMD_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    function automatic logic [CMD_W-1:0] pack_cmd(input logic [2:0] op,
                                                  input logic [3:0] a,
                                                  input logic [3:0] b);
        return {op, a, b};
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command queue: power-of-two ring buffer with a registered write-ready flag.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ready_q, ready_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign ready   = ready_q;

    // Pointer/occupancy update; ready is precomputed so it is a pure flop output
    // and stays low while reset is held.
    always_comb begin
        wr_ptr_d = wr_ptr_q + (do_push ? AW'(1) : AW'(0));
        rd_ptr_d = rd_ptr_q + (do_pop  ? AW'(1) : AW'(0));
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        ready_d  = (count_d != CW'(DEPTH));
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // Storage write; contents are don't-care until occupancy says otherwise
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/alu_issuer.sv
// Queues ALU commands and issues them one at a time to an external combinational ALU.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | nothing in flight; pop head as soon as the queue has one
//   ST_DRIVE | issue registers drive the ALU; capture result this edge
//   ST_RESP  | result held on res_*; wait for res_ready
module alu_issuer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [2:0] cmd_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_result,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [2:0] res_op,
    output logic       res_err,
    output logic       busy
);
    state_e           state_q, state_d;
    logic [3:0]       alu_a_q, alu_a_d;
    logic [3:0]       alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [7:0]       res_data_q, res_data_d;
    logic [2:0]       res_op_q, res_op_d;
    logic             res_err_q, res_err_d;
    logic             fifo_pop, fifo_full, fifo_empty, fifo_ready;
    logic [CMD_W-1:0] fifo_rdata;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid && fifo_ready),
        .wdata (pack_cmd(cmd_op, cmd_a, cmd_b)),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .ready (fifo_ready)
    );

    assign cmd_ready = fifo_ready;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign res_valid = (state_q == ST_RESP);
    assign res_data  = res_data_q;
    assign res_op    = res_op_q;
    assign res_err   = res_err_q;
    assign busy      = !fifo_empty || (state_q != ST_IDLE);

    // Next state, queue pop, issue-register load and result capture
    always_comb begin
        state_d    = state_q;
        fifo_pop   = 1'b0;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        res_data_d = res_data_q;
        res_op_d   = res_op_q;
        res_err_d  = res_err_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop                    = 1'b1;
                    {alu_op_d, alu_a_d, alu_b_d} = fifo_rdata;
                    state_d                     = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                res_op_d = alu_op_q;
                if (alu_op_q == OP_DIV && alu_b_q == 4'd0) begin
                    res_data_d = DIV_ZERO_RESULT;
                    res_err_d  = 1'b1;
                end else begin
                    res_data_d = alu_result;
                    res_err_d  = 1'b0;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (res_ready) begin
                    if (!fifo_empty) begin
                        // Back-to-back issue without passing through IDLE
                        fifo_pop                    = 1'b1;
                        {alu_op_d, alu_a_d, alu_b_d} = fifo_rdata;
                        state_d                     = ST_DRIVE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, issue and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            res_data_q <= '0;
            res_op_q   <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            res_data_q <= res_data_d;
            res_op_q   <= res_op_d;
            res_err_q  <= res_err_d;
        end
    end

    // fifo_full is implied by cmd_ready; kept for readability of the queue interface
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_alu_issuer.sv
// Directed bench for alu_issuer with a behavioural ALU on the alu_* port.
module tb_alu_issuer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a, cmd_b;
    logic [2:0] cmd_op;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_result;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [2:0] res_op;
    logic       res_err;
    logic       busy;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    alu_issuer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_op     (res_op),
        .res_err    (res_err),
        .busy       (busy)
    );

    function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [2:0] op);
        logic [7:0] ea, eb;
        ea = {4'h0, a};
        eb = {4'h0, b};
        case (op)
            3'd0: return ea + eb;
            3'd1: return ea - eb;
            3'd2: return ea * eb;
            3'd3: return (b == 4'd0) ? 8'h00 : ea / eb;
            3'd4: return ea << 3;
            3'd5: return ea >> 3;
            3'd6: return eb << 3;
            default: return eb >> 3;
        endcase
    endfunction

    assign alu_result = alu_model(alu_a, alu_b, alu_op);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; offers one command for one edge, returns at the next negedge.
    task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        output logic acc);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        acc       = cmd_ready;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Single command into an idle issuer with res_ready high.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [7:0] exp_data,
                         input logic exp_err);
        logic acc;
        int   cyc;
        send(op, a, b, acc);
        cyc = 0;
        while (!res_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"}, cyc, 2);
        chk({tag, "_data"}, res_data, exp_data);
        chk({tag, "_op"}, res_op, op);
        chk({tag, "_err"}, res_err, exp_err);
        @(negedge clk);
        chk({tag, "_drained"}, res_valid, 0);
    endtask

    logic [2:0] bp_op [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd0};
    logic [3:0] bp_a  [6] = '{4'h1, 4'h0, 4'hF, 4'h8, 4'h8, 4'h2};
    logic [3:0] bp_b  [6] = '{4'h2, 4'h1, 4'hF, 4'h3, 4'h0, 4'h2};
    logic [7:0] bp_exp[5] = '{8'h03, 8'hFF, 8'hE1, 8'h02, 8'h01};

    initial begin
        logic acc;
        int   nacc, nres, cyc, last_cyc;
        logic seen;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = '0;
        res_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_alu", {alu_op, alu_a, alu_b}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);
        chk("post_rst_busy", busy, 0);

        // Single operations
        do_op("add", 3'd0, 4'h9, 4'h8, 8'h11, 1'b0);
        chk("alu_hold_a", alu_a, 4'h9);
        chk("alu_hold_b", alu_b, 4'h8);
        chk("idle_busy", busy, 0);
        do_op("sub", 3'd1, 4'h3, 4'h5, 8'hFE, 1'b0);
        do_op("shl_a", 3'd4, 4'hF, 4'h0, 8'h78, 1'b0);
        do_op("div0", 3'd3, 4'h7, 4'h0, 8'hFF, 1'b1);
        do_op("div", 3'd3, 4'h9, 4'h2, 8'h04, 1'b0);
        do_op("mul", 3'd2, 4'h5, 4'h3, 8'h0F, 1'b0);
        do_op("shr_a", 3'd5, 4'hF, 4'h3, 8'h01, 1'b0);
        do_op("shl_b", 3'd6, 4'h1, 4'hF, 8'h78, 1'b0);
        do_op("shr_b", 3'd7, 4'h1, 4'hF, 8'h01, 1'b0);

        // Backpressure: fill the queue while the first result is stalled
        res_ready = 1'b0;
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            send(bp_op[i], bp_a[i], bp_b[i], acc);
            nacc += int'(acc);
        end
        chk("bp_accepted", nacc, 5);
        chk("bp_ready_low", cmd_ready, 0);
        chk("bp_valid", res_valid, 1);
        chk("bp_data0", res_data, 8'h03);
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        cmd_a     = 4'hF;
        cmd_b     = 4'hF;
        repeat (2) @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_stable_data", res_data, 8'h03);
        chk("bp_stable_op", res_op, 3'd0);
        chk("bp_still_full", cmd_ready, 0);

        res_ready = 1'b1;
        nres = 0;
        cyc = 0;
        last_cyc = -1;
        while (nres < 5 && cyc < 40) begin
            if (res_valid) begin
                chk("bp_res_data", res_data, bp_exp[nres]);
                chk("bp_res_op", res_op, bp_op[nres]);
                chk("bp_res_err", res_err, 0);
                last_cyc = cyc;
                nres++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("bp_num_results", nres, 5);
        chk("bp_throughput", last_cyc, 8);
        chk("bp_end_busy", busy, 0);
        chk("bp_end_valid", res_valid, 0);

        // Reset while a result is pending and three commands are queued
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(3'd0, 4'(i), 4'h1, acc);
        chk("mid_valid", res_valid, 1);
        chk("mid_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", res_valid, 0);
        chk("async_busy", busy, 0);
        chk("async_ready", cmd_ready, 0);
        chk("async_data", res_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        chk("no_ghost_results", seen, 0);
        chk("post_busy", busy, 0);
        chk("post_ready", cmd_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/alu_issuer.md
ALU_ISSUER -- requirements
Module: alu_issuer

Interface
REQ-001 Parameter DEPTH, default 4, meaning command-queue entries (power of two, >= 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 cmd_valid  input  1  upstream command present.
REQ-005 cmd_ready  output  1  queue can accept a command this cycle.
REQ-006 cmd_a, cmd_b  input  4 each  operands.
REQ-007 cmd_op  input  3  opcode (0 add, 1 sub, 2 mul, 3 div, 4 a<<3, 5 a>>3, 6 b<<3, 7 b>>3).
REQ-008 alu_a, alu_b  output  4 each  operands driven to the combinational ALU.
REQ-009 alu_op  output  3  opcode driven to the ALU.
REQ-010 alu_result  input  8  combinational ALU result.
REQ-011 res_valid  output  1  result available.
REQ-012 res_ready  input  1  downstream accepts result.
REQ-013 res_data  output  8  result value.
REQ-014 res_op  output  3  opcode that produced res_data.
REQ-015 res_err  output  1  divide-by-zero flag for this result.
REQ-016 busy  output  1  high when queue non-empty or FSM not IDLE.

Function
REQ-017 Command accepted on the edge where cmd_valid && cmd_ready; {op,a,b} written to queue tail.
REQ-018 cmd_ready = !full, from registered state only; no combinational path from any input.
REQ-019 Full queue: cmd_ready low, cmd_valid ignored, queue contents unchanged.
REQ-020 Push and pop on the same edge (queue not full): both occur, occupancy unchanged; pointers wrap modulo DEPTH.
REQ-021 FSM states IDLE, DRIVE, RESP.
REQ-022 IDLE: if queue non-empty, pop head into issue registers, go DRIVE; else stay.
REQ-023 DRIVE (exactly one cycle): alu_a/alu_b/alu_op driven from issue registers; at edge, res_data <= alu_result, res_op <= issued op, res_err <= 0; go RESP.
REQ-024 Divide-by-zero (op 3, b 0) in DRIVE: res_data <= 8'hFF, res_err <= 1, alu_result ignored.
REQ-025 RESP: res_valid high; res_data/res_op/res_err held stable until res_ready.
REQ-026 RESP with res_ready: if queue non-empty, pop next head and go DRIVE (no IDLE bubble); else go IDLE.
REQ-027 res_valid low in IDLE and DRIVE.
REQ-028 Latency: command accepted at edge N into empty queue with FSM IDLE -> res_valid high in cycle after edge N+2.
REQ-029 Sustained throughput with res_ready held high: one result per 2 cycles.
REQ-030 alu_* outputs hold last issued values outside DRIVE.
REQ-031 Non-div results pass alu_result unmodified (8-bit ALU wrap semantics, e.g. 3-5 = 8'hFE).

Reset
REQ-032 rst_n low asynchronously forces: FSM IDLE, queue empty (pointers, count 0), cmd_ready 0 while asserted, res_valid 0, res_data 0, res_op 0, res_err 0, alu_a/alu_b/alu_op 0, busy 0.
REQ-033 Reset mid-operation discards queued and in-flight commands; no result emitted after release.
REQ-034 First cycle after release: cmd_ready 1, FSM IDLE.

Structure
REQ-035 Shared package alu_pkg holds opcode constants (OP_ADD..OP_SHR_B), FSM state typedef, DIV_ZERO_RESULT = 8'hFF.
REQ-036 Queue implemented as sub-module alu_cmd_fifo (parameter DEPTH, width 11, push/pop, full/empty).

Verification
REQ-037 Bench connects alu_a/alu_b/alu_op to the team's combinational ALU and checks each result against a model.
REQ-038 Single add a=9,b=8 at edge N -> res_valid at N+3, res_data 8'h11, res_op 0, res_err 0.
REQ-039 Sub a=3,b=5 -> res_data 8'hFE; shift op 4 a=4'hF -> 8'h78.
REQ-040 Div a=7,b=0 -> res_data 8'hFF, res_err 1; following div a=9,b=2 -> 8'h04, res_err 0.
REQ-041 res_ready low, push 6 commands (DEPTH 4) -> 5 accepted (4 queued + 1 issued), cmd_ready low, outputs stable; release res_ready -> 5 results in order.
REQ-042 Assert rst_n low while RESP with 3 queued -> res_valid 0 immediately, busy 0, no results after release.
